modulation_sequencer: RTL and testbench
=======================================

Name: modulation_sequencer

Overview:
- Generates per-segment modulation sample indices, the active segment and the stop flag consumed by the modulation multiplier (IDX[], SEGMENT, STOP).
- Advances the active segment's index on each frame tick through a per-segment frequency divider.
- Applies segment-switch requests with selectable transition timing and finite/infinite loop counts.
- Sits between the CPU-side config/control registers and the modulation multiplier.

Parameters:
- IDX_W, 15, sample index width; must match the modulation buffer address width.
- DIV_W, 16, frequency-divider width.
- REP_W, 16, loop-count width.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; asynchronous, active-low.
- UPDATE  in  1  one-cycle frame tick; advances the sequencer.
- CYCLE[params::NumSegment]  in  IDX_W each  last valid sample index of each segment.
- FREQ_DIV[params::NumSegment]  in  DIV_W each  UPDATE ticks per sample; 0 is treated as 1.
- REP[params::NumSegment]  in  REP_W each  segment plays REP+1 loops; params::RepInfinite means loop forever.
- REQ_VALID  in  1  segment-switch request.
- REQ_SEGMENT  in  1  target segment.
- REQ_MODE  in  2  params::mod_transition_t: IMMEDIATE=0, AT_WRAP=1, EXT_SYNC=2; 3 is treated as IMMEDIATE.
- SYNC  in  1  external sync pulse for EXT_SYNC.
- REQ_READY  out  1  request can be accepted.
- IDX[params::NumSegment]  out  IDX_W each  current sample index per segment.
- SEGMENT  out  1  active segment.
- STOP  out  1  modulation frozen.
- BUSY  out  1  a transition is pending.

Behaviour:
- Reset (asynchronous, immediate): IDX all 0, SEGMENT=0, STOP=0, BUSY=0, REQ_READY=1, internal loop mode infinite, divider counters 0, state IDLE.
- All outputs are registered.

Advance (on UPDATE, STOP=0, no switch applied in that cycle):
- The active segment's divider increments.
- When divider ≥ FREQ_DIV-1: divider→0 and the index advances.
  - If IDX ≥ CYCLE, that advance is a wrap: IDX→0. Using ≥ covers a CYCLE shrunk at runtime.
  - Otherwise IDX+1.
- On a wrap, in finite mode: if loop counter = 0, assert STOP and hold IDX at its last value (no wrap); else decrement the loop counter.
- The inactive segment's IDX and divider hold.
- STOP=1: nothing advances; STOP clears only on an applied switch.

Request FSM, states IDLE, WAIT_WRAP, WAIT_SYNC:
- REQ_READY = (state==IDLE); accept on REQ_VALID & REQ_READY, then latch segment and mode.
- IMMEDIATE: apply in the acceptance cycle; state stays IDLE.
- AT_WRAP → WAIT_WRAP: apply on the first UPDATE that would wrap the active segment, or the first UPDATE if STOP=1.
- EXT_SYNC → WAIT_SYNC: apply in the first cycle with SYNC=1 strictly after acceptance. SYNC in the acceptance cycle is ignored.
- BUSY = state≠IDLE.

Apply:
- SEGMENT←target; IDX[target]←0; divider[target]←0; STOP←0.
- Loop counter←REP[target], infinite if REP[target]=RepInfinite; REP is sampled at apply time.
- State→IDLE.
- Targeting the current segment restarts it.

Simultaneous events:
- An apply and an advance in the same cycle: the apply wins, and the new segment starts at IDX 0 with no increment that cycle.
- An apply and a STOP condition in the same cycle: the apply wins, and STOP=0.

Latency:
- Effects appear in outputs the cycle after the triggering edge (UPDATE, accept or SYNC).

Config changes:
- CYCLE, FREQ_DIV and REP are sampled live, with no shadowing.

Decomposition:
- Package params holds NumSegment (2), mod_transition_t enum and RepInfinite = '1.
- Sub-module modulation_segment_counter (one per segment): divider, index, wrap-detect and clear/enable inputs.
- The top level holds the FSM, loop counter, STOP and the segment register.

Test Plan:
- Reset; CYCLE0=3, FREQ_DIV0=1, REP0=RepInfinite; 10 UPDATEs → IDX[0]=1,2,3,0,1,2,3,0,1,2; SEGMENT=0, STOP=0.
- FREQ_DIV0=3, CYCLE0=3; 9 UPDATEs → IDX[0] steps to 1, 2, 3 after UPDATEs 3, 6, 9; a FREQ_DIV0=0 run matches FREQ_DIV0=1.
- REP0=1, CYCLE0=1; IMMEDIATE request to seg0, then 6 UPDATEs → IDX[0]=1,0,1,1,1,1; STOP rises on UPDATE 4 and stays high.
- CYCLE0=3, IDX[0]=1; AT_WRAP request to seg1 → REQ_READY=0, BUSY=1; UPDATEs give IDX[0]=2, 3, then SEGMENT=1, IDX[1]=0, IDX[0] held 3, BUSY=0.
- EXT_SYNC request to seg1 with SYNC=1 in the acceptance cycle → no switch; SYNC 5 cycles later → SEGMENT=1 the next cycle.
- RST_N low while in WAIT_WRAP with SEGMENT=1 → same cycle, without a clock: SEGMENT=0, IDX=0, REQ_READY=1, BUSY=0, STOP=0.

Source files
------------

// File: rtl/modulation_sequencer_pkg.sv
// Shared types and constants for the modulation sequencer: segment count,
// transition modes and request FSM states.
`default_nettype none

package modulation_sequencer_pkg;

    localparam int unsigned NUM_SEGMENT = 2;
    localparam int unsigned SEG_W       = 1;

    typedef enum logic [1:0] {
        MODE_IMMEDIATE = 2'd0,
        MODE_AT_WRAP   = 2'd1,
        MODE_EXT_SYNC  = 2'd2
    } mod_transition_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_WRAP = 2'd1,
        ST_WAIT_SYNC = 2'd2
    } req_state_t;

endpackage

`default_nettype wire

// File: rtl/modulation_segment_counter.sv
// Per-segment frequency divider and sample index with wrap detection.
`default_nettype none

module modulation_segment_counter #(
    parameter int IDX_W = 15,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             hold_i,
    input  logic [IDX_W-1:0] cycle_i,
    input  logic [DIV_W-1:0] freq_div_i,
    output logic             wrap_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [DIV_W-1:0] div_q, div_d, div_last;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             div_hit;

    always_comb begin
        div_last = (freq_div_i == '0) ? '0 : freq_div_i - DIV_W'(1);
        // >= rather than == keeps the divider sane if FREQ_DIV or CYCLE shrink at runtime
        div_hit  = (div_q >= div_last);
        wrap_o   = div_hit && (idx_q >= cycle_i);
        div_d    = div_q;
        idx_d    = idx_q;
        if (clear_i) begin
            div_d = '0;
            idx_d = '0;
        end else if (enable_i) begin
            if (div_hit) begin
                div_d = '0;
                if (wrap_o) begin
                    if (!hold_i) begin
                        idx_d = '0;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

`default_nettype wire

// File: rtl/modulation_sequencer.sv
// Modulation sequencer: per-segment index generation, segment-switch request
// FSM, loop counting and stop control.
`default_nettype none

module modulation_sequencer
    import modulation_sequencer_pkg::*;
#(
    parameter int IDX_W = 15,
    parameter int DIV_W = 16,
    parameter int REP_W = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                update_i,
    input  logic [NUM_SEGMENT-1:0][IDX_W-1:0]   cycle_i,
    input  logic [NUM_SEGMENT-1:0][DIV_W-1:0]   freq_div_i,
    input  logic [NUM_SEGMENT-1:0][REP_W-1:0]   rep_i,
    input  logic                                req_valid_i,
    input  logic [SEG_W-1:0]                    req_segment_i,
    input  logic [1:0]                          req_mode_i,
    input  logic                                sync_i,
    output logic                                req_ready_o,
    output logic [NUM_SEGMENT-1:0][IDX_W-1:0]   idx_o,
    output logic [SEG_W-1:0]                    segment_o,
    output logic                                stop_o,
    output logic                                busy_o
);

    localparam logic [REP_W-1:0] REP_INFINITE = '1;

    req_state_t       state_q, state_d;
    logic [SEG_W-1:0] tgt_q, tgt_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             stop_q, stop_d;
    logic [REP_W-1:0] loop_cnt_q, loop_cnt_d;
    logic             loop_inf_q, loop_inf_d;
    logic             ready_q, busy_q;

    logic                   apply_w;
    logic [SEG_W-1:0]       apply_tgt_w;
    logic                   adv_w;
    logic                   hold_w;
    logic                   active_wrap_w;
    logic [NUM_SEGMENT-1:0] wrap_w;

    assign adv_w         = update_i && !stop_q;
    assign hold_w        = !loop_inf_q && (loop_cnt_q == '0);
    assign active_wrap_w = wrap_w[seg_q];

    generate
        for (genvar s = 0; s < NUM_SEGMENT; s++) begin : g_seg
            modulation_segment_counter #(
                .IDX_W (IDX_W),
                .DIV_W (DIV_W)
            ) u_counter (
                .clk        (clk),
                .rst_n      (rst_n),
                .clear_i    (apply_w && (apply_tgt_w == SEG_W'(s))),
                .enable_i   (adv_w && !apply_w && (seg_q == SEG_W'(s))),
                .hold_i     (hold_w),
                .cycle_i    (cycle_i[s]),
                .freq_div_i (freq_div_i[s]),
                .wrap_o     (wrap_w[s]),
                .idx_o      (idx_o[s])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        apply_w     = 1'b0;
        apply_tgt_w = tgt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    tgt_d = req_segment_i;
                    case (req_mode_i)
                        MODE_AT_WRAP:  state_d = ST_WAIT_WRAP;
                        MODE_EXT_SYNC: state_d = ST_WAIT_SYNC;
                        default: begin
                            apply_w     = 1'b1;
                            apply_tgt_w = req_segment_i;
                        end
                    endcase
                end
            end
            ST_WAIT_WRAP: begin
                // A stopped segment never wraps, so the next tick releases it instead
                if (update_i && (stop_q || active_wrap_w)) begin
                    apply_w = 1'b1;
                end
            end
            ST_WAIT_SYNC: begin
                if (sync_i) begin
                    apply_w = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (apply_w) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        seg_d      = seg_q;
        stop_d     = stop_q;
        loop_cnt_d = loop_cnt_q;
        loop_inf_d = loop_inf_q;
        if (apply_w) begin
            seg_d      = apply_tgt_w;
            stop_d     = 1'b0;
            loop_cnt_d = rep_i[apply_tgt_w];
            loop_inf_d = (rep_i[apply_tgt_w] == REP_INFINITE);
        end else if (adv_w && active_wrap_w && !loop_inf_q) begin
            if (hold_w) begin
                stop_d = 1'b1;
            end else begin
                loop_cnt_d = loop_cnt_q - REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tgt_q      <= '0;
            seg_q      <= '0;
            stop_q     <= 1'b0;
            loop_cnt_q <= '0;
            loop_inf_q <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            seg_q      <= seg_d;
            stop_q     <= stop_d;
            loop_cnt_q <= loop_cnt_d;
            loop_inf_q <= loop_inf_d;
            ready_q    <= (state_d == ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign segment_o   = seg_q;
    assign stop_o      = stop_q;
    assign req_ready_o = ready_q;
    assign busy_o      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_modulation_sequencer.sv
// Self-checking bench for modulation_sequencer: directed scenarios followed by
// randomized traffic compared against a behavioural model.
`default_nettype none

module tb_modulation_sequencer;
    import modulation_sequencer_pkg::*;

    localparam int IDX_W = 15;
    localparam int DIV_W = 16;
    localparam int REP_W = 16;

    logic                              clk = 1'b0;
    logic                              rst_n = 1'b0;
    logic                              update_i = 1'b0;
    logic [NUM_SEGMENT-1:0][IDX_W-1:0] cycle_i;
    logic [NUM_SEGMENT-1:0][DIV_W-1:0] freq_div_i;
    logic [NUM_SEGMENT-1:0][REP_W-1:0] rep_i;
    logic                              req_valid_i = 1'b0;
    logic [SEG_W-1:0]                  req_segment_i = '0;
    logic [1:0]                        req_mode_i = 2'd0;
    logic                              sync_i = 1'b0;
    logic                              req_ready_o;
    logic [NUM_SEGMENT-1:0][IDX_W-1:0] idx_o;
    logic [SEG_W-1:0]                  segment_o;
    logic                              stop_o;
    logic                              busy_o;

    modulation_sequencer #(
        .IDX_W (IDX_W),
        .DIV_W (DIV_W),
        .REP_W (REP_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .update_i      (update_i),
        .cycle_i       (cycle_i),
        .freq_div_i    (freq_div_i),
        .rep_i         (rep_i),
        .req_valid_i   (req_valid_i),
        .req_segment_i (req_segment_i),
        .req_mode_i    (req_mode_i),
        .sync_i        (sync_i),
        .req_ready_o   (req_ready_o),
        .idx_o         (idx_o),
        .segment_o     (segment_o),
        .stop_o        (stop_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: loops_left = -1 means loop forever; pend 0/1/2 = none/at-wrap/sync
    int m_idx [2];
    int m_tick[2];
    int m_seg, m_loops, m_pend, m_tgt;
    bit m_stop;

    int exp_free [10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    int exp_div3 [9]  = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
    int exp_div0 [4]  = '{1, 2, 3, 0};
    int exp_rep  [6]  = '{1, 0, 1, 1, 1, 1};
    int exp_stop [6]  = '{0, 0, 0, 1, 1, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx  = '{0, 0};
        m_tick = '{0, 0};
        m_seg  = 0;
        m_loops = -1;
        m_pend = 0;
        m_tgt  = 0;
        m_stop = 1'b0;
    endtask

    function automatic int period(input int s);
        return (freq_div_i[s] == 0) ? 1 : int'(freq_div_i[s]);
    endfunction

    function automatic bit would_wrap(input int s);
        return (m_tick[s] + 1 >= period(s)) && (m_idx[s] >= int'(cycle_i[s]));
    endfunction

    task automatic model_edge(input logic upd, input logic syn, input logic rv,
                              input logic rs, input logic [1:0] rm);
        bit apply = 1'b0;
        int tgt   = m_tgt;
        int s;
        if (m_pend == 0 && rv) begin
            if (rm == 2'd1) begin
                m_pend = 1;
                m_tgt  = int'(rs);
            end else if (rm == 2'd2) begin
                m_pend = 2;
                m_tgt  = int'(rs);
            end else begin
                apply = 1'b1;
                tgt   = int'(rs);
            end
        end else if (m_pend == 1 && upd && (m_stop || would_wrap(m_seg))) begin
            apply = 1'b1;
        end else if (m_pend == 2 && syn) begin
            apply = 1'b1;
        end

        if (apply) begin
            m_seg       = tgt;
            m_idx[tgt]  = 0;
            m_tick[tgt] = 0;
            m_stop      = 1'b0;
            m_loops     = (rep_i[tgt] == {REP_W{1'b1}}) ? -1 : int'(rep_i[tgt]);
            m_pend      = 0;
        end else if (upd && !m_stop) begin
            s = m_seg;
            if (m_tick[s] + 1 >= period(s)) begin
                m_tick[s] = 0;
                if (m_idx[s] >= int'(cycle_i[s])) begin
                    if (m_loops == 0) begin
                        m_stop = 1'b1;
                    end else begin
                        m_idx[s] = 0;
                        if (m_loops > 0) m_loops--;
                    end
                end else begin
                    m_idx[s]++;
                end
            end else begin
                m_tick[s]++;
            end
        end
    endtask

    task automatic check_model();
        chk("idx0",    idx_o[0],    m_idx[0]);
        chk("idx1",    idx_o[1],    m_idx[1]);
        chk("segment", segment_o,   m_seg);
        chk("stop",    stop_o,      m_stop);
        chk("busy",    busy_o,      m_pend != 0);
        chk("ready",   req_ready_o, m_pend == 0);
    endtask

    task automatic step(input logic upd, input logic syn, input logic rv,
                        input logic rs, input logic [1:0] rm);
        update_i      = upd;
        sync_i        = syn;
        req_valid_i   = rv;
        req_segment_i = rs;
        req_mode_i    = rm;
        model_edge(upd, syn, rv, rs, rm);
        @(posedge clk);
        #1;
        update_i    = 1'b0;
        sync_i      = 1'b0;
        req_valid_i = 1'b0;
        check_model();
    endtask

    initial begin
        cycle_i    = '{15'd3, 15'd3};
        freq_div_i = '{16'd1, 16'd1};
        rep_i      = '{16'hFFFF, 16'hFFFF};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_idx0",  idx_o[0], 0);
        chk("reset_seg",   segment_o, 0);
        chk("reset_ready", req_ready_o, 1);
        check_model();
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running infinite loop over CYCLE=3
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
            chk("free_idx0", idx_o[0], exp_free[i]);
        end

        // Divide by 3, then divide by 0 behaving as 1
        freq_div_i[0] = 16'd3;
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
            chk("div3_idx0", idx_o[0], exp_div3[i]);
        end
        freq_div_i[0] = 16'd0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
            chk("div0_idx0", idx_o[0], exp_div0[i]);
        end

        // Finite loops: REP=1 plays two passes then freezes
        freq_div_i[0] = 16'd1;
        cycle_i[0]    = 15'd1;
        rep_i[0]      = 16'd1;
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
            chk("rep_idx0", idx_o[0], exp_rep[i]);
            chk("rep_stop", stop_o, exp_stop[i]);
        end

        // AT_WRAP switch to segment 1
        cycle_i[0] = 15'd3;
        rep_i[0]   = 16'hFFFF;
        cycle_i[1] = 15'd2;
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        chk("restart_stop", stop_o, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
        chk("atwrap_ready", req_ready_o, 0);
        chk("atwrap_busy",  busy_o, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("atwrap_idx0_a", idx_o[0], 2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("atwrap_idx0_b", idx_o[0], 3);
        chk("atwrap_seg_b",  segment_o, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("atwrap_seg",  segment_o, 1);
        chk("atwrap_idx1", idx_o[1], 0);
        chk("atwrap_idx0", idx_o[0], 3);
        chk("atwrap_done", busy_o, 0);

        // EXT_SYNC: sync in the acceptance cycle is ignored
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd2);
        chk("sync_seg_hold", segment_o, 0);
        chk("sync_busy",     busy_o, 1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
            chk("sync_wait_seg", segment_o, 0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        chk("sync_seg", segment_o, 1);

        // Asynchronous reset while waiting for a wrap on segment 1
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd1);
        chk("pre_rst_busy", busy_o, 1);
        chk("pre_rst_seg",  segment_o, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_seg",   segment_o, 0);
        chk("arst_idx0",  idx_o[0], 0);
        chk("arst_idx1",  idx_o[1], 0);
        chk("arst_ready", req_ready_o, 1);
        chk("arst_busy",  busy_o, 0);
        chk("arst_stop",  stop_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic, including runtime config changes
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                for (int s = 0; s < NUM_SEGMENT; s++) begin
                    cycle_i[s]    = IDX_W'($urandom_range(0, 4));
                    freq_div_i[s] = DIV_W'($urandom_range(0, 3));
                    rep_i[s]      = ($urandom_range(0, 2) == 0) ? {REP_W{1'b1}}
                                                                : REP_W'($urandom_range(0, 3));
                end
            end
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
